controle_cpu: RTL and testbench
===============================

Name: controle_cpu

Overview:
- Control/issue stage that sits directly upstream of the mini-CPU ALU (`operacoes`).
- Accepts one 18-bit instruction per handshake, decodes it and reads the 16x16 register file.
- Drives the ALU operand ports, waits out the ALU's one-cycle registered output, then writes the result back.
- Also implements the two opcodes the ALU leaves unused: SHOW (110) and CLEAR (111).

Parameters:
- NREG, 16, number of architectural registers (must be 16; the 4-bit register fields depend on it)
- W, 16, data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  18  instruction: [17:15] opcode, [14:11] dest, [10:7] src1, [6:3] src2, [6:0] imm (src2 and imm overlap)
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  block can accept an instruction
- alu_opcode  out  3  to ALU opcode
- alu_r2  out  16  to ALU r2 (regs[src1])
- alu_r3  out  16  to ALU r3 (regs[src2])
- alu_d1  out  4  to ALU D1 (dest)
- alu_imm  out  7  to ALU entrada
- alu_result  in  16  from ALU saida
- result  out  16  value written (or shown) by the last completed instruction
- result_dest  out  4  dest register of the last completed instruction
- done  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (sync, rst=1 at an edge):
  - state=IDLE; all 16 registers=0.
  - All outputs=0 except instr_ready=1 (IDLE).
  - rst during any state aborts the instruction: no writeback, no done.
- FSM states: IDLE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. At edge k with instr_valid=1, latch the fields. alu_opcode/alu_d1/alu_imm <= fields; alu_r2 <= regs[src1]; alu_r3 <= regs[src2]. Go to EXEC.
  - EXEC: instr_ready=0; ALU operands held stable. The ALU registers its result at edge k+1. Go to WB.
  - WB: at edge k+2, act on opcode:
    - 000-101: regs[dest] <= alu_result.
    - 110 SHOW: no register write; result <= held alu_r2 (= regs[src1]).
    - 111 CLEAR: all regs <= 0; result <= 0.
    - All opcodes: result_dest <= dest; done <= 1 for exactly one cycle; state <= IDLE.
- Outputs:
  - result = alu_result for 000-101.
  - alu_* outputs keep their last values in IDLE.
  - ALU saida for 110/111 is ignored (the ALU outputs 0 there).
- Latency: done is visible in the cycle after edge k+2. Throughput: next accept at edge k+3 at the earliest (one instruction per 3 cycles).
- instr_valid while not ready: ignored. The source must hold the instruction until ready.
- Read-after-write: the writeback at k+2 precedes the next read at k+3, so no forwarding is needed.
- Arithmetic: none in this block. Values pass through unmodified; no sign handling here (the ALU sign-extends imm).
- Duplicate sources (src1==src2) or dest==src: legal; operands are read before the write.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode localparams LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, SHOW=110, CLEAR=111
  - instruction field bit positions
  - FSM state encoding
- The ALU uses the same opcode constants from the package.
- One natural sub-module: `banco_registradores`: 16x16 array with two combinational read ports, one synchronous write port, synchronous clear and rst.

Test Plan:
- Reset then LOAD r1,imm=0x05 -> done after 3 cycles; result=0x0005; result_dest=1; regs[1]=5.
- LOAD r2,imm=0x7F (-1), then ADD r3,r1,r2 with r1=5 -> alu_r2=5, alu_r3=0xFFFF; result=0x0004 in r3.
- SUBI r4,r1,imm=3 then MUL r5,r4,r4 -> regs[4]=2, regs[5]=4. instr_ready stays low for 2 cycles after each accept.
- SHOW r1 after LOAD r1,9 -> result=0x0009; no register changes; done pulse 1 cycle wide.
- CLEAR, then SHOW r3 -> result=0; every register reads 0.
- Assert rst in EXEC of ADD r6 -> no done; regs[6]=0; instr_ready=1 the cycle after the reset edge. An instruction held on instr_valid while busy is accepted only once ready rises.

Source files
------------

// File: rtl/controle_cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and FSM encoding shared by controle_cpu and the ALU
package cpu_pkg;
  localparam logic [2:0] LOAD  = 3'b000;
  localparam logic [2:0] ADD   = 3'b001;
  localparam logic [2:0] ADDI  = 3'b010;
  localparam logic [2:0] SUB   = 3'b011;
  localparam logic [2:0] SUBI  = 3'b100;
  localparam logic [2:0] MUL   = 3'b101;
  localparam logic [2:0] SHOW  = 3'b110;
  localparam logic [2:0] CLEAR = 3'b111;
  localparam int OP_HI   = 17;
  localparam int OP_LO   = 15;
  localparam int DST_HI  = 14;
  localparam int DST_LO  = 11;
  localparam int SRC1_HI = 10;
  localparam int SRC1_LO = 7;
  localparam int SRC2_HI = 6;
  localparam int SRC2_LO = 3;
  localparam int IMM_HI  = 6;
  localparam int IMM_LO  = 0;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/controle_cpu_if.sv
// controle_cpu_if: instruction handshake, ALU operand/result and completion signals.
//   master = instruction source + ALU side, slave = controle_cpu
interface controle_cpu_if #(parameter int W = 16);
  logic [17:0]  instr;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_r2;
  logic [W-1:0] alu_r3;
  logic [3:0]   alu_d1;
  logic [6:0]   alu_imm;
  logic [W-1:0] alu_result;
  logic [W-1:0] result;
  logic [3:0]   result_dest;
  logic         done;
  modport master (
    output instr, instr_valid, alu_result,
    input  instr_ready, alu_opcode, alu_r2, alu_r3, alu_d1, alu_imm, result, result_dest, done
  );
  modport slave (
    input  instr, instr_valid, alu_result,
    output instr_ready, alu_opcode, alu_r2, alu_r3, alu_d1, alu_imm, result, result_dest, done
  );
endinterface

// File: rtl/controle_cpu_banco_registradores.sv
// banco_registradores: NREG x W register file, two combinational read ports, one sync write port, sync clear/rst.
//   clk, rst: clock, sync active-high reset; clr: zero all registers; we/waddr/wdata: write port;
//   raddr1/raddr2 -> rdata1/rdata2: read ports
module banco_registradores #(
  parameter int NREG = 16,
  parameter int W    = 16,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2
);
  logic [W-1:0] regs [NREG];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  always_ff @(posedge clk) begin
    if (rst || clr) regs <= '{default: '0};
    else if (we) regs[waddr] <= wdata;
  end
endmodule

// File: rtl/controle_cpu.sv
// controle_cpu: issue stage that decodes an instruction, feeds the ALU, waits its registered result and writes back.
//   clk, rst: clock, sync active-high reset
//   bus (slave): instr/instr_valid/instr_ready handshake, alu_* operands out, alu_result in,
//                result/result_dest/done report the last completed instruction
module controle_cpu
  import cpu_pkg::*;
#(
  parameter int NREG = 16,
  parameter int W    = 16
) (
  input logic clk,
  input logic rst,
  controle_cpu_if.slave bus
);
  state_t state, nxt;
  logic [W-1:0] rd1, rd2;
  logic accept, in_wb;
  assign accept = state == IDLE && bus.instr_valid;
  assign in_wb  = state == WB;
  assign bus.instr_ready = state == IDLE;
  banco_registradores #(.NREG(NREG), .W(W)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .clr    (in_wb && bus.alu_opcode == CLEAR),
    .we     (in_wb && bus.alu_opcode < SHOW),
    .waddr  (bus.alu_d1),
    .wdata  (bus.alu_result),
    .raddr1 (bus.instr[SRC1_HI:SRC1_LO]),
    .raddr2 (bus.instr[SRC2_HI:SRC2_LO]),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (bus.instr_valid ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
  end
  // Operands are captured on accept and held until the next accept so the ALU sees them stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_opcode  <= '0;
      bus.alu_r2      <= '0;
      bus.alu_r3      <= '0;
      bus.alu_d1      <= '0;
      bus.alu_imm     <= '0;
      bus.result      <= '0;
      bus.result_dest <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= in_wb;
      if (accept) begin
        bus.alu_opcode <= bus.instr[OP_HI:OP_LO];
        bus.alu_d1     <= bus.instr[DST_HI:DST_LO];
        bus.alu_imm    <= bus.instr[IMM_HI:IMM_LO];
        bus.alu_r2     <= rd1;
        bus.alu_r3     <= rd2;
      end
      if (in_wb) begin
        bus.result      <= bus.alu_opcode == SHOW ? bus.alu_r2 : bus.alu_opcode == CLEAR ? '0 : bus.alu_result;
        bus.result_dest <= bus.alu_d1;
      end
    end
  end
endmodule

// File: tb/tb_controle_cpu.sv
// tb_controle_cpu: directed self-checking bench for controle_cpu with a behavioural one-cycle ALU
module tb_controle_cpu;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  controle_cpu_if #(.W(16)) bus ();
  controle_cpu dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] sext(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction
  always @(posedge clk) begin
    case (bus.alu_opcode)
      LOAD:    bus.alu_result <= sext(bus.alu_imm);
      ADD:     bus.alu_result <= bus.alu_r2 + bus.alu_r3;
      ADDI:    bus.alu_result <= bus.alu_r2 + sext(bus.alu_imm);
      SUB:     bus.alu_result <= bus.alu_r2 - bus.alu_r3;
      SUBI:    bus.alu_result <= bus.alu_r2 - sext(bus.alu_imm);
      MUL:     bus.alu_result <= 16'(bus.alu_r2 * bus.alu_r3);
      default: bus.alu_result <= 16'h0000;
    endcase
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] enc(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, s2, 3'b000};
  endfunction
  function automatic logic [17:0] enci(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1, input logic [6:0] imm);
    return {op, d, s1, imm};
  endfunction
  // Issue one instruction and check ready low for two cycles, done on the third, one cycle wide.
  task automatic run(input string tag, input logic [17:0] ins);
    int n;
    @(negedge clk);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    n = 0;
    while (!bus.instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 16'(bus.instr_ready), 16'h1);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_busy1"}, {15'd0, bus.instr_ready, bus.done} , 16'h0);
    @(negedge clk);
    chk({tag, "_busy2"}, {15'd0, bus.instr_ready, bus.done}, 16'h0);
    @(negedge clk);
    chk({tag, "_done"}, 16'(bus.done), 16'h1);
  endtask
  task automatic after_pulse(input string tag);
    @(negedge clk);
    chk({tag, "_pulse"}, 16'(bus.done), 16'h0);
  endtask
  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 16'(bus.instr_ready), 16'h1);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_result", bus.result, 16'h0);
    chk("rst_dest", 16'(bus.result_dest), 16'h0);
    chk("rst_r2", bus.alu_r2, 16'h0);
    chk("rst_op", 16'(bus.alu_opcode), 16'h0);
    run("load_r1", enci(LOAD, 4'd1, 4'd0, 7'h05));
    chk("load_r1_result", bus.result, 16'h0005);
    chk("load_r1_dest", 16'(bus.result_dest), 16'h1);
    chk("regs1", dut.u_rf.regs[1], 16'h0005);
    after_pulse("load_r1");
    run("load_r2", enci(LOAD, 4'd2, 4'd0, 7'h7F));
    chk("load_r2_result", bus.result, 16'hFFFF);
    run("add_r3", enc(ADD, 4'd3, 4'd1, 4'd2));
    chk("add_alu_r2", bus.alu_r2, 16'h0005);
    chk("add_alu_r3", bus.alu_r3, 16'hFFFF);
    chk("add_result", bus.result, 16'h0004);
    chk("regs3", dut.u_rf.regs[3], 16'h0004);
    run("subi_r4", enci(SUBI, 4'd4, 4'd1, 7'h03));
    chk("subi_result", bus.result, 16'h0002);
    chk("regs4", dut.u_rf.regs[4], 16'h0002);
    run("mul_r5", enc(MUL, 4'd5, 4'd4, 4'd4));
    chk("mul_result", bus.result, 16'h0004);
    chk("regs5", dut.u_rf.regs[5], 16'h0004);
    run("load_r1b", enci(LOAD, 4'd1, 4'd0, 7'h09));
    run("show_r1", enc(SHOW, 4'd7, 4'd1, 4'd0));
    chk("show_result", bus.result, 16'h0009);
    chk("show_dest", 16'(bus.result_dest), 16'h7);
    chk("show_regs7", dut.u_rf.regs[7], 16'h0000);
    chk("show_regs1", dut.u_rf.regs[1], 16'h0009);
    after_pulse("show");
    run("clear", enc(CLEAR, 4'd0, 4'd0, 4'd0));
    chk("clear_result", bus.result, 16'h0000);
    for (int i = 0; i < 16; i++) chk($sformatf("clear_regs%0d", i), dut.u_rf.regs[i], 16'h0000);
    run("load_r3", enci(LOAD, 4'd3, 4'd0, 7'h12));
    run("clear2", enc(CLEAR, 4'd0, 4'd0, 4'd0));
    run("show_r3", enc(SHOW, 4'd3, 4'd3, 4'd0));
    chk("show_r3_result", bus.result, 16'h0000);
    // Held instruction: B stays on instr_valid while A executes and is taken only at k+3.
    @(negedge clk);
    bus.instr = enci(LOAD, 4'd8, 4'd0, 7'h11);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr = enci(LOAD, 4'd9, 4'd0, 7'h22);
    @(negedge clk);
    chk("held_busy1", {15'd0, bus.instr_ready}, 16'h0);
    @(negedge clk);
    chk("held_busy2", {15'd0, bus.instr_ready}, 16'h0);
    @(negedge clk);
    chk("held_a_done", 16'(bus.done), 16'h1);
    chk("held_a_result", bus.result, 16'h0011);
    chk("held_a_dest", 16'(bus.result_dest), 16'h8);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("held_b_d1", 16'(bus.alu_d1), 16'h9);
    chk("held_b_busy1", {15'd0, bus.instr_ready, bus.done}, 16'h0);
    @(negedge clk);
    chk("held_b_busy2", {15'd0, bus.instr_ready, bus.done}, 16'h0);
    @(negedge clk);
    chk("held_b_done", 16'(bus.done), 16'h1);
    chk("held_b_result", bus.result, 16'h0022);
    chk("regs8", dut.u_rf.regs[8], 16'h0011);
    chk("regs9", dut.u_rf.regs[9], 16'h0022);
    after_pulse("held_b");
    // Reset during EXEC aborts the ADD.
    run("load_r1c", enci(LOAD, 4'd1, 4'd0, 7'h05));
    @(negedge clk);
    bus.instr = enc(ADD, 4'd6, 4'd1, 4'd1);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_exec_ready", 16'(bus.instr_ready), 16'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 16'(bus.instr_ready), 16'h1);
    chk("abort_done0", 16'(bus.done), 16'h0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 16'(bus.done), 16'h0);
    end
    chk("abort_regs6", dut.u_rf.regs[6], 16'h0000);
    chk("abort_result", bus.result, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
